// File: rtl/insert_metadata_pkg.sv
// Shared definitions for the transmit-side metadata inserter: FSM encoding,
// timestamp width and the byte strobe used on the metadata beat.
package insert_metadata_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_PKT = 2'd1,
        BYPASS = 2'd2
    } state_t;

    localparam int TS_WIDTH = 32;

    // Metadata beat carries only the timestamp bytes.
    localparam logic [TS_WIDTH/8-1:0] META_TSTRB = '1;

endpackage

// File: rtl/insert_metadata_fallthrough_small_fifo.sv
// Small fall-through FIFO: registered write, head visible combinationally on dout.
// Latency: 1 cycle from write to head valid; read is same-cycle on rd_en.
// Backpressure: nearly_full at DEPTH-1 entries; writes when full are dropped.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] DEPTH_V   = DEPTH[MAX_DEPTH_BITS:0];
    localparam logic [MAX_DEPTH_BITS:0] NEARLY_V  = DEPTH_V - 1'b1;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      wr_ok;
    logic                      rd_ok;

    assign full        = (depth == DEPTH_V);
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= NEARLY_V);
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/insert_metadata.sv
// Prepends a metadata beat carrying the tuser timestamp to each packet, then clears that field.
// Latency: metadata beat valid 1 cycle after first beat is accepted; data beats fall through.
// Backpressure: s_axis_tready drops at 3 buffered beats; head held until m_axis_tready.
module insert_metadata
    import insert_metadata_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TUSER_TIMESTAMP_POS = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_reset,
    input  logic                                 sw_rst,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    input  logic                                 s_axis_tlast,
    output logic                                 s_axis_tready,

    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    input  logic                                 im_enable,
    output logic [31:0]                          pkt_count
);

    localparam int DW     = C_S_AXIS_DATA_WIDTH;
    localparam int UW     = C_S_AXIS_TUSER_WIDTH;
    localparam int FIFO_W = DW + UW + DW/8 + 1;
    localparam logic [UW-1:0] TS_MASK =
        {{(UW-TS_WIDTH){1'b0}}, {TS_WIDTH{1'b1}}} << C_TUSER_TIMESTAMP_POS;

    logic              rst;
    logic              fifo_wr_en;
    logic              fifo_rd_en;
    logic              fifo_nearly_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_dout;

    logic [DW-1:0]       head_dat;
    logic [DW/8-1:0]     head_strb;
    logic [UW-1:0]       head_user;
    logic                head_last;
    logic [UW-1:0]       head_user_clr;
    logic [TS_WIDTH-1:0] head_ts;

    state_t state;
    state_t state_nxt;

    assign rst           = axi_reset || sw_rst;
    assign s_axis_tready = !fifo_nearly_full && !rst;
    assign fifo_wr_en    = s_axis_tvalid && s_axis_tready;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (2)
    ) u_in_fifo (
        .clk         (axi_aclk),
        .reset       (rst),
        .din         ({s_axis_tlast, s_axis_tstrb, s_axis_tuser, s_axis_tdata}),
        .wr_en       (fifo_wr_en),
        .rd_en       (fifo_rd_en),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    assign {head_last, head_strb, head_user, head_dat} = fifo_dout;
    assign head_ts       = head_user[C_TUSER_TIMESTAMP_POS +: TS_WIDTH];
    assign head_user_clr = head_user & ~TS_MASK;

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The metadata beat is built from the head without popping it.
    always_comb begin
        state_nxt = state;
        if (!fifo_empty) begin
            case (state)
                IDLE: begin
                    if (!im_enable)         state_nxt = BYPASS;
                    else if (m_axis_tready) state_nxt = WR_PKT;
                end
                WR_PKT, BYPASS: begin
                    if (m_axis_tready && head_last) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tlast  = 1'b0;
        fifo_rd_en    = 1'b0;
        if (!rst && !fifo_empty) begin
            case (state)
                IDLE: begin
                    if (im_enable) begin
                        m_axis_tvalid                 = 1'b1;
                        m_axis_tdata[TS_WIDTH-1:0]    = head_ts;
                        m_axis_tstrb[TS_WIDTH/8-1:0]  = META_TSTRB;
                        m_axis_tuser                  = head_user;
                    end
                end
                WR_PKT, BYPASS: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = head_dat;
                    m_axis_tstrb  = head_strb;
                    m_axis_tuser  = (state == WR_PKT) ? head_user_clr : head_user;
                    m_axis_tlast  = head_last;
                    fifo_rd_en    = m_axis_tready;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (state == WR_PKT && fifo_rd_en && head_last) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_insert_metadata.sv
// Directed bench for insert_metadata: scoreboard of hand-built expected beats,
// stall-stability monitor, reset/sw_rst, nearly-full and im_enable toggle cases.
module tb_insert_metadata;

    logic         axi_aclk = 1'b0;
    logic         axi_reset;
    logic         sw_rst;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tstrb;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         im_enable;
    logic [31:0]  pkt_count;

    always #5 axi_aclk = ~axi_aclk;

    insert_metadata dut (
        .axi_aclk      (axi_aclk),
        .axi_reset     (axi_reset),
        .sw_rst        (sw_rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .im_enable     (im_enable),
        .pkt_count     (pkt_count)
    );

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    int    checks   = 0;
    int    failures = 0;
    beat_t exp_q[$];
    bit    rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk_beat(input logic [31:0] ts, input logic [31:0] base,
                                      input int i, input bit last);
        beat_t b;
        b.d = {16{base + 32'(i)}};
        b.s = last ? 64'h0000_0000_FFFF_FFFF : '1;
        b.u = {32'hA5A5_0000 | 32'(i), 32'h1234_5678, ts, 32'h0000_00C0 | 32'(i)};
        b.l = last;
        return b;
    endfunction

    function automatic beat_t meta_of(input beat_t f);
        beat_t m;
        m.d        = '0;
        m.d[31:0]  = f.u[63:32];
        m.s        = 64'h0000_0000_0000_000F;
        m.u        = f.u;
        m.l        = 1'b0;
        return m;
    endfunction

    function automatic beat_t clr(input beat_t b);
        beat_t c = b;
        c.u[63:32] = '0;
        return c;
    endfunction

    // Output scoreboard and stall-stability check.
    logic         prev_stall = 1'b0;
    logic [511:0] prev_dat;
    beat_t        mon_e;
    always @(negedge axi_aclk) begin
        if (prev_stall) begin
            chk("stall_vld", 512'(m_axis_tvalid), 512'(1));
            chk("stall_dat", m_axis_tdata, prev_dat);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_dat   = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 512'(m_axis_tvalid), 512'(0));
            end else begin
                mon_e = exp_q.pop_front();
                chk("tdata", m_axis_tdata, mon_e.d);
                chk("tstrb", 512'(m_axis_tstrb), 512'(mon_e.s));
                chk("tuser", 512'(m_axis_tuser), 512'(mon_e.u));
                chk("tlast", 512'(m_axis_tlast), 512'(mon_e.l));
            end
        end
    end

    always @(posedge axi_aclk) begin
        if (rand_rdy) begin
            #1;
            m_axis_tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive_beat(input beat_t b);
        logic acc;
        s_axis_tdata  = b.d;
        s_axis_tstrb  = b.s;
        s_axis_tuser  = b.u;
        s_axis_tlast  = b.l;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge axi_aclk);
            acc = s_axis_tready;
            @(posedge axi_aclk);
            #1;
            if (acc) begin
                s_axis_tvalid = 1'b0;
                return;
            end
        end
        chk("s_tready_timeout", 512'(s_axis_tready), 512'(1));
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input logic [31:0] ts, input logic [31:0] base,
                            input bit meta, input int toggle_at);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b = mk_beat(ts, base, i, i == n - 1);
            if (i == 0 && meta) exp_q.push_back(meta_of(b));
            exp_q.push_back(meta ? clr(b) : b);
            drive_beat(b);
            if (i == toggle_at) im_enable = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge axi_aclk);
        end
        chk("drain", 512'(exp_q.size()), 512'(0));
        repeat (2) @(posedge axi_aclk);
        #1;
    endtask

    initial begin
        beat_t b;
        beat_t nf_b[4];
        int    idx;
        logic  acc;

        axi_reset     = 1'b1;
        sw_rst        = 1'b0;
        im_enable     = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tlast  = 1'b0;

        // Reset state
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        chk("rst_s_rdy", 512'(s_axis_tready), 512'(0));
        chk("rst_m_vld", 512'(m_axis_tvalid), 512'(0));
        chk("rst_m_last", 512'(m_axis_tlast), 512'(0));
        chk("rst_m_dat", m_axis_tdata, '0);
        chk("rst_cnt", 512'(pkt_count), 512'(0));
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        @(negedge axi_aclk);
        chk("rdy_after_rst", 512'(s_axis_tready), 512'(1));
        @(posedge axi_aclk);
        #1;

        // 3-beat packet, timestamp 0xDEADBEEF, with 1-cycle metadata latency
        im_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b = mk_beat(32'hDEAD_BEEF, 32'h0000_0100, i, i == 2);
            if (i == 0) exp_q.push_back(meta_of(b));
            exp_q.push_back(clr(b));
            drive_beat(b);
            if (i == 0) begin
                @(negedge axi_aclk);
                chk("lat_vld", 512'(m_axis_tvalid), 512'(1));
                chk("lat_ts", m_axis_tdata, 512'hDEAD_BEEF);
                chk("lat_strb", 512'(m_axis_tstrb), 512'h0F);
                @(posedge axi_aclk);
                #1;
            end
        end
        drain();
        chk("cnt_t1", 512'(pkt_count), 512'(1));

        // Single-beat packet
        send_pkt(1, 32'h0BAD_F00D, 32'h0000_0200, 1'b1, -1);
        drain();
        chk("cnt_single", 512'(pkt_count), 512'(2));

        // Bypass: tuser untouched, count unchanged
        im_enable = 1'b0;
        send_pkt(2, 32'hCAFE_0001, 32'h0000_0300, 1'b0, -1);
        drain();
        chk("cnt_bypass", 512'(pkt_count), 512'(2));

        // Stalled output: only 3 beats accepted before s_axis_tready drops
        im_enable     = 1'b1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nf_b[i] = mk_beat(32'h1111_2222, 32'h0000_0400, i, i == 3);
            if (i == 0) exp_q.push_back(meta_of(nf_b[i]));
            exp_q.push_back(clr(nf_b[i]));
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            s_axis_tdata  = nf_b[idx].d;
            s_axis_tstrb  = nf_b[idx].s;
            s_axis_tuser  = nf_b[idx].u;
            s_axis_tlast  = nf_b[idx].l;
            s_axis_tvalid = 1'b1;
            @(negedge axi_aclk);
            acc = s_axis_tready;
            @(posedge axi_aclk);
            #1;
            if (acc) idx++;
        end
        s_axis_tvalid = 1'b0;
        chk("nf_accepts", 512'(idx), 512'(3));
        @(negedge axi_aclk);
        chk("nf_s_rdy", 512'(s_axis_tready), 512'(0));
        @(posedge axi_aclk);
        #1;
        m_axis_tready = 1'b1;
        drive_beat(nf_b[3]);
        drain();
        chk("cnt_nf", 512'(pkt_count), 512'(3));

        // im_enable drops mid-packet: current packet keeps metadata, next is bypassed
        send_pkt(4, 32'h5555_AAAA, 32'h0000_0500, 1'b1, 1);
        send_pkt(2, 32'h6666_BBBB, 32'h0000_0600, 1'b0, -1);
        drain();
        chk("cnt_toggle", 512'(pkt_count), 512'(4));

        // 100 back-to-back packets with random output backpressure
        im_enable = 1'b1;
        rand_rdy  = 1'b1;
        for (int p = 0; p < 100; p++) begin
            send_pkt(p % 3 + 1, 32'hF000_0000 + 32'(p), 32'h0001_0000 + 32'(p * 16), 1'b1, -1);
        end
        drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge axi_aclk);
        #2;
        m_axis_tready = 1'b1;
        chk("cnt_random", 512'(pkt_count), 512'(104));

        // sw_rst mid-packet
        b = mk_beat(32'h7777_8888, 32'h0000_0700, 0, 1'b0);
        exp_q.push_back(meta_of(b));
        exp_q.push_back(clr(b));
        drive_beat(b);
        repeat (3) @(posedge axi_aclk);
        #1;
        sw_rst = 1'b1;
        @(negedge axi_aclk);
        chk("swrst_s_rdy", 512'(s_axis_tready), 512'(0));
        chk("swrst_m_vld", 512'(m_axis_tvalid), 512'(0));
        chk("swrst_partial", 512'(exp_q.size()), 512'(0));
        @(posedge axi_aclk);
        #1;
        sw_rst = 1'b0;
        @(negedge axi_aclk);
        chk("post_swrst_vld", 512'(m_axis_tvalid), 512'(0));
        chk("post_swrst_cnt", 512'(pkt_count), 512'(0));
        chk("post_swrst_rdy", 512'(s_axis_tready), 512'(1));
        @(posedge axi_aclk);
        #1;
        send_pkt(2, 32'h9999_0000, 32'h0000_0800, 1'b1, -1);
        drain();
        chk("cnt_after_swrst", 512'(pkt_count), 512'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
